serial_logic_unit: RTL and testbench
====================================

# serial_logic_unit

Parametrised, multi-cycle bitwise logic unit for the integer ALU. It generalises the fixed 4-bit combinational XOR gate to any operand width, eight bitwise operations and a SLICE-bits-per-cycle serial datapath. Valid/ready handshakes sit on both the operand and result sides. It also produces registered zero and parity flags for the ALU status logic.

## Interface
- WIDTH, default 8: operand/result width in bits; must be ≥1.
- SLICE, default 2: bits processed per cycle; must divide WIDTH exactly. A violation is an elaboration error. BEATS = WIDTH/SLICE.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, asynchronous assert, active-low.
- in_valid  input  1: operand transfer request.
- in_ready  output  1: high only in IDLE; transfer occurs on an edge where in_valid & in_ready.
- a  input  WIDTH: operand A, sampled at transfer.
- b  input  WIDTH: operand B, sampled at transfer.
- op  input  3: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A.
- out_valid  output  1: result, zero and parity are valid.
- out_ready  input  1: consumer accepts the result on an edge where out_valid & out_ready.
- result  output  WIDTH: registered result.
- zero  output  1: result == 0.
- parity  output  1: XOR-reduction of result (1 = odd number of ones).

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE→RUN on transfer.
  - a, b and op are latched into internal registers.
  - Beat counter cleared; result cleared; zero accumulator set to 1; parity accumulator cleared.
  - Input pins are ignored after transfer until the next IDLE.
- RUN, beat k (k = 0..BEATS-1), processed LSB-first:
  - result[k*SLICE +: SLICE] = op applied to slice k of latched a and b.
  - zero ← zero & (slice == 0).
  - parity ← parity ^ (^slice).
  - Counter increments.
  - Bits above the current slice stay 0 until written.
- RUN→DONE on the edge that writes beat BEATS-1.
- DONE→IDLE on the edge where out_ready=1.
  - result, zero and parity hold their values until the next transfer overwrites them.
  - out_valid drops.
- No overlap. A new transfer is only accepted from IDLE, so the minimum initiation interval is BEATS+2 cycles.
- In DONE, result, zero and parity are stable for as long as out_ready stays low; there is no timeout.
- in_valid is ignored outside IDLE. in_valid need not be held after transfer.

## Timing
- Reset (rst_n=0), immediate and asynchronous:
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, parity=0.
  - Counter and latched operands cleared.
- Reset mid-RUN or mid-DONE: operation aborted, result discarded, no out_valid.
- After rst_n deasserts, a transfer is possible on the first rising edge.
- Latency: transfer at edge E0, slice k written at edge E(k+1), out_valid high after edge E(BEATS).
  - Defaults (WIDTH=8, SLICE=2): out_valid rises 4 cycles after the transfer edge.
  - SLICE=WIDTH: 1 cycle.
- out_ready high in the same cycle out_valid rises: result is consumed at the next edge, and in_ready is high in the following cycle.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- zero and parity are meaningful only while out_valid=1.

## Test plan
- XOR transfer, a=8'b1100_1100, b=8'b1001_1001, op=010, out_ready=1 → after 4 cycles out_valid=1, result=8'b0101_0101, zero=0, parity=0; in_ready low for exactly 5 cycles.
- XOR of equal operands, a=b=8'hA5 → result=8'h00, zero=1, parity=0.
- All ops on a=8'hF0, b=8'h3C (out_ready=1 throughout, so every result is consumed) → AND 30, OR FC, XOR CC, NAND CF, NOR 03, XNOR 33, NOT A 0F, PASS A F0.
  - Parity: AND/XOR/NAND/XNOR/NOT A/PASS A give 0; OR gives 0 (six ones); NOR gives 0.
  - zero=0 for every op.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling a, b, in_valid → result, zero and parity unchanged, no second transfer; releasing out_ready returns to IDLE next edge.
- Reset mid-RUN: pull rst_n low after beat 2 of an XOR → outputs immediately at reset values; after release, a fresh transfer of a=8'h01, b=8'h00 with XOR gives result=8'h01, zero=0, parity=1.
- Parameter sweep: instantiate WIDTH=4/SLICE=4 and WIDTH=16/SLICE=4 → latencies of 1 and 4 cycles; a=16'hFFFF, b=16'h0001 with XOR gives 16'hFFFE, parity=1.

Source files
------------

// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per cycle, LSB first, with zero/parity flags.
// Latency WIDTH/SLICE cycles after transfer; operands accepted only in IDLE, result held in DONE until out_ready.
module serial_logic_unit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int BEATS = WIDTH / SLICE;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("serial_logic_unit: SLICE must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               parity_q, parity_d;

    logic [31:0]        shamt;
    logic [SLICE-1:0]   sa, sb, so;
    logic               last_beat;

    // Current slice is selected by shifting the latched operands down by cnt*SLICE.
    always_comb begin
        shamt     = 32'(cnt_q) * SLICE;
        sa        = SLICE'(a_q >> shamt);
        sb        = SLICE'(b_q >> shamt);
        last_beat = (cnt_q == CNT_W'(BEATS - 1));
        so        = '0;
        case (op_q)
            3'b000:  so = sa & sb;
            3'b001:  so = sa | sb;
            3'b010:  so = sa ^ sb;
            3'b011:  so = ~(sa & sb);
            3'b100:  so = ~(sa | sb);
            3'b101:  so = ~(sa ^ sb);
            3'b110:  so = ~sa;
            default: so = sa;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    cnt_d    = '0;
                    result_d = '0;
                    zero_d   = 1'b1;
                    parity_d = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Upper bits are still zero here, so OR-ing the slice in writes it in place.
                result_d = result_q | (WIDTH'(so) << shamt);
                zero_d   = zero_q & (so == '0);
                parity_d = parity_q ^ (^so);
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: randomized traffic against a word-level model plus directed cases.
module tb_serial_logic_unit;

    localparam int BEATS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic [2:0] op = '0;
    logic       in_ready, out_valid, zero, parity;
    logic [7:0] result;

    logic       iv4 = 1'b0, or4 = 1'b1;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] op4 = '0;
    logic       ir4, ov4, z4, p4;
    logic [3:0] r4;

    logic        iv16 = 1'b0, or16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  op16 = '0;
    logic        ir16, ov16, z16, p16;
    logic [15:0] r16;

    int total = 0;
    int bad = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    serial_logic_unit #(.WIDTH(8), .SLICE(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity)
    );

    serial_logic_unit #(.WIDTH(4), .SLICE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .op(op4), .out_valid(ov4), .out_ready(or4),
        .result(r4), .zero(z4), .parity(p4)
    );

    serial_logic_unit #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .op(op16), .out_valid(ov16), .out_ready(or16),
        .result(r16), .zero(z16), .parity(p16)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    // Word-level model: busy flag, cycles since transfer, full answer, and the last delivered answer.
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [7:0] m_full = '0;
    logic [7:0] m_hold = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_full <= '0;
            m_hold <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_full <= ref_op(a, b, op);
            end
        end else if (m_t < BEATS) begin
            m_t <= m_t + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_hold <= m_full;
        end
    end

    function automatic logic [7:0] exp_result();
        logic [7:0] ones;
        ones = 8'hFF;
        if (!m_busy) return m_hold;
        if (m_t >= BEATS) return m_full;
        return m_full & (ones >> (8 - m_t * 2));
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("mon_in_ready", 32'(in_ready), 32'(!m_busy));
            chk("mon_out_valid", 32'(out_valid), 32'(m_busy && m_t == BEATS));
            chk("mon_result", 32'(result), 32'(exp_result()));
            if (m_busy && m_t == BEATS) begin
                chk("mon_zero", 32'(zero), 32'(m_full == 8'h00));
                chk("mon_parity", 32'(parity), 32'(^m_full));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o,
                          input logic [7:0] er, input logic ez, input logic ep, input string nm);
        int lat, lo;
        logic seen;
        lat = 0; lo = 0; seen = 1'b0;
        @(negedge clk);
        a = x; b = y; op = o; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!in_ready) lo++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                chk({nm, "_lat"}, 32'(lat), 32'(BEATS));
                chk({nm, "_res"}, 32'(result), 32'(er));
                chk({nm, "_zero"}, 32'(zero), 32'(ez));
                chk({nm, "_par"}, 32'(parity), 32'(ep));
            end
            if (in_ready) break;
            @(posedge clk);
            if (!seen) lat++;
            @(negedge clk);
        end
        chk({nm, "_seen"}, 32'(seen), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(lo), 32'd5);
    endtask

    initial begin
        int lat;
        logic [7:0] ops_exp [8];
        ops_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_parity", 32'(parity), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_op(8'b1100_1100, 8'b1001_1001, 3'b010, 8'b0101_0101, 1'b0, 1'b0, "xor_basic");
        run_op(8'hA5, 8'hA5, 3'b010, 8'h00, 1'b1, 1'b0, "xor_equal");
        for (int k = 0; k < 8; k++)
            run_op(8'hF0, 8'h3C, 3'(k), ops_exp[k], 1'b0, 1'b0, $sformatf("op%0d", k));

        // Backpressure: result must hold while inputs wiggle in DONE.
        @(negedge clk);
        a = 8'hF0; b = 8'h3C; op = 3'b001; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("bp_result", 32'(result), 32'hFC);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
        end
        chk("bp_hold_result", 32'(result), 32'hFC);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Randomized traffic, checked every cycle by the monitor.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom % 3) == 0;
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom);
            out_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Reset in the middle of RUN.
        a = 8'hCC; b = 8'h99; op = 3'b010; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd0);
        chk("mid_rst_parity", 32'(parity), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h00, 3'b010, 8'h01, 1'b0, 1'b1, "post_rst");

        // WIDTH=4, SLICE=4: single-beat latency.
        @(negedge clk);
        a4 = 4'hA; b4 = 4'h6; op4 = 3'b010; iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !ov4; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w4_valid", 32'(ov4), 32'd1);
        chk("w4_lat", 32'(lat), 32'd1);
        chk("w4_res", 32'(r4), 32'hC);
        chk("w4_par", 32'(p4), 32'd0);

        // WIDTH=16, SLICE=4: four beats.
        a16 = 16'hFFFF; b16 = 16'h0001; op16 = 3'b010; iv16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !ov16; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w16_valid", 32'(ov16), 32'd1);
        chk("w16_lat", 32'(lat), 32'd4);
        chk("w16_res", 32'(r16), 32'hFFFE);
        chk("w16_zero", 32'(z16), 32'd0);
        chk("w16_par", 32'(p16), 32'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
